// File: rtl/vcxo_pump_modulator_pkg.sv
// Shared constants and types for the VCXO charge-pump modulator.
// PERIOD/DUTY_INIT defaults track the loop controller's PWM_max and initial PWM.
package vcxo_pump_modulator_pkg;

    localparam int unsigned PERIOD_DEFAULT        = 60000;
    localparam int unsigned DUTY_INIT_DEFAULT     = 30000;
    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;
    localparam int unsigned DW_DEFAULT            = 32;

    typedef enum logic {
        MODE_PWM = 1'b0,
        MODE_SD  = 1'b1
    } mode_e;

    typedef struct packed {
        logic        clamped;
        logic [15:0] duty;
    } duty_t;

endpackage

// File: rtl/vcxo_duty_sync.sv
// Retimes a quasi-static control word from a foreign domain and only accepts
// it after it has been seen unchanged for STABLE_CYCLES consecutive samples.
module vcxo_duty_sync #(
    parameter int unsigned   DW            = 32,
    parameter int unsigned   STABLE_CYCLES = 4,
    parameter logic [DW-1:0] INIT          = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_word,
    output logic [DW-1:0] o_pending
);

    localparam int unsigned   SW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_ONE = SW'(1);

    logic [DW-1:0] r_s1;
    logic [DW-1:0] r_s2;
    logic [DW-1:0] r_pending;
    logic [SW-1:0] r_stab;
    logic          w_same;

    assign w_same    = (r_s1 == r_s2);
    assign o_pending = r_pending;

    // Sample chain, saturating stability counter and accept register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1      <= INIT;
            r_s2      <= INIT;
            r_stab    <= '0;
            r_pending <= INIT;
        end else begin
            r_s1 <= i_word;
            r_s2 <= r_s1;
            if (!w_same) begin
                r_stab <= '0;
            end else if (r_stab != STAB_MAX) begin
                r_stab <= r_stab + STAB_ONE;
            end else begin
                r_stab <= r_stab;
            end
            // Load only on the transition into the saturated state.
            if (w_same && (r_stab == (STAB_MAX - STAB_ONE))) begin
                r_pending <= r_s2;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

endmodule

// File: rtl/vcxo_pump_modulator.sv
// Charge-pump modulator: clamps the accepted duty word once per period and
// drives the pump pin as classic PWM or first-order sigma-delta.
module vcxo_pump_modulator
    import vcxo_pump_modulator_pkg::*;
#(
    parameter int unsigned PERIOD        = PERIOD_DEFAULT,
    parameter int unsigned DUTY_INIT     = DUTY_INIT_DEFAULT,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned DW            = DW_DEFAULT
) (
    input  logic                 pwm_clk_in,
    input  logic                 reset_n,
    input  logic signed [DW-1:0] PWM,
    input  logic                 mode,
    input  logic                 enable,
    output logic                 pump,
    output logic [15:0]          duty_active,
    output logic                 period_strobe,
    output logic                 duty_update,
    output logic                 clamped
);

    localparam logic [15:0]          CNT_LAST  = 16'(PERIOD - 1);
    localparam logic [15:0]          PERIOD_16 = 16'(PERIOD);
    localparam logic [16:0]          PERIOD_17 = 17'(PERIOD);
    localparam logic [15:0]          DUTY_RST  = 16'(DUTY_INIT);
    localparam logic signed [DW-1:0] ZERO_S    = '0;
    localparam logic signed [DW-1:0] PERIOD_S  = DW'(PERIOD);

    function automatic duty_t clamp_duty(input logic signed [DW-1:0] p);
        duty_t d;
        if (p < ZERO_S) begin
            d.clamped = 1'b1;
            d.duty    = 16'd0;
        end else if (p > PERIOD_S) begin
            d.clamped = 1'b1;
            d.duty    = PERIOD_16;
        end else begin
            d.clamped = 1'b0;
            d.duty    = p[15:0];
        end
        return d;
    endfunction

    logic [DW-1:0] w_pending;
    duty_t         w_load;
    logic          w_wrap;
    logic [15:0]   w_cnt_next;
    logic [16:0]   w_sum;
    logic          w_pump_next;
    logic [15:0]   w_acc_next;

    logic [15:0]   r_cnt;
    logic [15:0]   r_acc;
    logic [15:0]   r_duty;
    mode_e         r_mode_act;
    logic          r_pump;
    logic          r_strobe;
    logic          r_update;
    logic          r_clamped;

    vcxo_duty_sync #(
        .DW            (DW),
        .STABLE_CYCLES (STABLE_CYCLES),
        .INIT          (DW'(DUTY_INIT))
    ) u_sync (
        .i_clk     (pwm_clk_in),
        .i_rst_n   (reset_n),
        .i_word    (PWM),
        .o_pending (w_pending)
    );

    assign w_load     = clamp_duty($signed(w_pending));
    assign w_wrap     = (r_cnt == CNT_LAST);
    assign w_cnt_next = w_wrap ? 16'd0 : (r_cnt + 16'd1);

    // Next pump bit and accumulator for the active modulation mode.
    always_comb begin
        w_sum       = {1'b0, r_acc} + {1'b0, r_duty};
        w_pump_next = 1'b0;
        w_acc_next  = 16'd0;
        case (r_mode_act)
            MODE_SD: begin
                if (w_sum >= PERIOD_17) begin
                    w_pump_next = 1'b1;
                    w_acc_next  = 16'(w_sum - PERIOD_17);
                end else begin
                    w_pump_next = 1'b0;
                    w_acc_next  = w_sum[15:0];
                end
            end
            default: begin
                w_pump_next = (r_cnt < r_duty);
                w_acc_next  = 16'd0;
            end
        endcase
    end

    // Period counter, duty/mode reload at the wrap, and registered pump drive.
    always_ff @(posedge pwm_clk_in) begin
        if (!reset_n) begin
            r_cnt      <= 16'd0;
            r_acc      <= 16'd0;
            r_duty     <= DUTY_RST;
            r_mode_act <= MODE_PWM;
            r_pump     <= 1'b0;
            r_strobe   <= 1'b0;
            r_update   <= 1'b0;
            r_clamped  <= 1'b0;
        end else if (!enable) begin
            // Idle: hold a fresh period ready while duty and mode track inputs.
            r_cnt      <= 16'd0;
            r_acc      <= 16'd0;
            r_pump     <= 1'b0;
            r_strobe   <= 1'b0;
            r_duty     <= w_load.duty;
            r_clamped  <= w_load.clamped;
            r_mode_act <= mode_e'(mode);
            r_update   <= (w_load.duty != r_duty);
        end else begin
            r_cnt    <= w_cnt_next;
            r_pump   <= w_pump_next;
            r_strobe <= (w_cnt_next == CNT_LAST);
            if (w_wrap) begin
                r_acc      <= 16'd0;
                r_duty     <= w_load.duty;
                r_clamped  <= w_load.clamped;
                r_mode_act <= mode_e'(mode);
                r_update   <= (w_load.duty != r_duty);
            end else begin
                r_acc      <= w_acc_next;
                r_duty     <= r_duty;
                r_clamped  <= r_clamped;
                r_mode_act <= r_mode_act;
                r_update   <= 1'b0;
            end
        end
    end

    assign pump          = r_pump;
    assign duty_active   = r_duty;
    assign period_strobe = r_strobe;
    assign duty_update   = r_update;
    assign clamped       = r_clamped;

endmodule

// File: tb/tb_vcxo_pump_modulator.sv
// Directed bench for vcxo_pump_modulator with PERIOD=10, DUTY_INIT=5.
// Pump patterns are indexed by the counter value each pump bit was computed from.
module tb_vcxo_pump_modulator;

    logic               clk = 1'b0;
    logic               reset_n;
    logic signed [31:0] pwm_word;
    logic               mode;
    logic               enable;
    logic               pump;
    logic [15:0]        duty_active;
    logic               period_strobe;
    logic               duty_update;
    logic               clamped;

    int checks   = 0;
    int failures = 0;

    localparam logic [9:0] PAT_ZERO = 10'b0000000000;
    localparam logic [9:0] PAT_ONES = 10'b1111111111;
    localparam logic [9:0] PAT_C5   = 10'b0000011111;
    localparam logic [9:0] PAT_C3   = 10'b0000000111;
    localparam logic [9:0] PAT_C6   = 10'b0000111111;
    localparam logic [9:0] PAT_SD3  = 10'b1001001000;
    localparam logic [9:0] PAT_SD2  = 10'b1000010000;
    localparam logic [9:0] PAT_SD5  = 10'b1010101010;

    vcxo_pump_modulator #(
        .PERIOD        (10),
        .DUTY_INIT     (5),
        .STABLE_CYCLES (4),
        .DW            (32)
    ) dut (
        .pwm_clk_in    (clk),
        .reset_n       (reset_n),
        .PWM           (pwm_word),
        .mode          (mode),
        .enable        (enable),
        .pump          (pump),
        .duty_active   (duty_active),
        .period_strobe (period_strobe),
        .duty_update   (duty_update),
        .clamped       (clamped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input logic ep, input logic es, input string tag);
        tick();
        chk({tag, ".pump"}, 32'(pump), 32'(ep));
        chk({tag, ".strobe"}, 32'(period_strobe), 32'(es));
    endtask

    task automatic run_range(input logic [9:0] pat, input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            tick_chk(pat[i], (i == 8), tag);
        end
    endtask

    task automatic run_period(input logic [9:0] pat, input string tag);
        run_range(pat, 0, 9, tag);
        chk({tag, ".acc_at_wrap"}, 32'(dut.r_acc), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b1;
        mode     = 1'b0;
        pwm_word = 32'sd5;
        repeat (3) tick();
        chk("rst.pump", 32'(pump), 32'd0);
        chk("rst.duty", 32'(duty_active), 32'd5);
        chk("rst.strobe", 32'(period_strobe), 32'd0);
        chk("rst.update", 32'(duty_update), 32'd0);
        chk("rst.clamped", 32'(clamped), 32'd0);
        reset_n = 1'b1;

        // Test 1: classic PWM at duty 5, then a change to 3
        run_period(PAT_C5, "t1.c5a");
        run_period(PAT_C5, "t1.c5b");
        pwm_word = 32'sd3;
        for (int i = 0; i < 10; i++) begin
            tick_chk(PAT_C5[i], (i == 8), "t1.latency");
            if (i == 4) chk("t1.pending_before", dut.w_pending, 32'd5);
            if (i == 5) chk("t1.pending_after", dut.w_pending, 32'd3);
        end
        chk("t1.duty3", 32'(duty_active), 32'd3);
        chk("t1.update_pulse", 32'(duty_update), 32'd1);
        chk("t1.clamped0", 32'(clamped), 32'd0);
        run_range(PAT_C3, 0, 0, "t1.c3");
        chk("t1.update_fall", 32'(duty_update), 32'd0);
        run_range(PAT_C3, 1, 9, "t1.c3");

        // Test 2: sigma-delta spreading of duty 3
        mode = 1'b1;
        run_period(PAT_C3, "t2.pre");
        chk("t2.no_update", 32'(duty_update), 32'd0);
        run_period(PAT_SD3, "t2.sd3a");
        run_period(PAT_SD3, "t2.sd3b");

        // Test 3: clamping below zero and above full scale
        pwm_word = -32'sd7;
        run_period(PAT_SD3, "t3.pre_neg");
        chk("t3.duty0", 32'(duty_active), 32'd0);
        chk("t3.clamped_neg", 32'(clamped), 32'd1);
        chk("t3.update_neg", 32'(duty_update), 32'd1);
        run_period(PAT_ZERO, "t3.zero_a");
        run_period(PAT_ZERO, "t3.zero_b");
        pwm_word = 32'sd12;
        run_period(PAT_ZERO, "t3.pre_big");
        chk("t3.duty10", 32'(duty_active), 32'd10);
        chk("t3.clamped_big", 32'(clamped), 32'd1);
        run_period(PAT_ONES, "t3.sd_full");
        mode = 1'b0;
        run_period(PAT_ONES, "t3.sd_full_b");
        run_period(PAT_ONES, "t3.pwm_full");
        chk("t3.clamped_sticky", 32'(clamped), 32'd1);

        // Test 4: toggling input never accepted, then held value accepted
        for (int j = 0; j < 20; j++) begin
            pwm_word = (((j / 2) % 2) == 0) ? 32'sd6 : 32'sd4;
            tick_chk(1'b1, ((j % 10) == 8), "t4.toggle");
            chk("t4.pending_hold", dut.w_pending, 32'd12);
        end
        pwm_word = 32'sd6;
        for (int i = 0; i < 10; i++) begin
            tick_chk(1'b1, (i == 8), "t4.hold");
            if (i == 4) chk("t4.pending_before", dut.w_pending, 32'd12);
            if (i == 5) chk("t4.pending_after", dut.w_pending, 32'd6);
        end
        chk("t4.duty6", 32'(duty_active), 32'd6);
        chk("t4.clamped_clear", 32'(clamped), 32'd0);
        chk("t4.update", 32'(duty_update), 32'd1);
        run_period(PAT_C6, "t4.c6");

        // Test 5: enable drop at cnt=7, duty/mode tracking while idle, reset
        run_range(PAT_C6, 0, 6, "t5.pre");
        enable   = 1'b0;
        mode     = 1'b1;
        pwm_word = 32'sd2;
        for (int t = 1; t <= 8; t++) begin
            tick_chk(1'b0, 1'b0, "t5.idle");
            chk("t5.cnt_idle", 32'(dut.r_cnt), 32'd0);
            if (t == 6) chk("t5.duty_old", 32'(duty_active), 32'd6);
            if (t == 7) chk("t5.duty_new", 32'(duty_active), 32'd2);
            if (t == 7) chk("t5.update_idle", 32'(duty_update), 32'd1);
            if (t == 8) chk("t5.update_fall", 32'(duty_update), 32'd0);
        end
        enable = 1'b1;
        run_period(PAT_SD2, "t5.fresh_sd2");
        run_range(PAT_SD2, 0, 3, "t5.pre_rst");
        reset_n  = 1'b0;
        pwm_word = 32'sd5;
        mode     = 1'b0;
        tick();
        chk("t5.rst_pump", 32'(pump), 32'd0);
        chk("t5.rst_duty", 32'(duty_active), 32'd5);
        chk("t5.rst_strobe", 32'(period_strobe), 32'd0);
        chk("t5.rst_update", 32'(duty_update), 32'd0);
        chk("t5.rst_clamped", 32'(clamped), 32'd0);
        chk("t5.rst_cnt", 32'(dut.r_cnt), 32'd0);
        chk("t5.rst_acc", 32'(dut.r_acc), 32'd0);
        reset_n = 1'b1;
        run_period(PAT_C5, "t5.after_rst");

        // Test 6: mode toggled mid-period takes effect only at the wrap
        run_range(PAT_C5, 0, 3, "t6.a");
        mode = 1'b1;
        run_range(PAT_C5, 4, 9, "t6.a");
        run_period(PAT_SD5, "t6.sd5");
        run_range(PAT_SD5, 0, 3, "t6.b");
        mode = 1'b0;
        run_range(PAT_SD5, 4, 9, "t6.b");
        chk("t6.acc_zero", 32'(dut.r_acc), 32'd0);
        run_period(PAT_C5, "t6.c5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
